// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-enable SRAM block.
package memory_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned be_width(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/mem_be_array.sv
// Word storage with one byte-enabled write port and one registered read port.
module mem_be_array
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BE_WIDTH   = be_width(WIDTH),
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  clr_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [BE_WIDTH-1:0]   wbe_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic                  rzero_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin : write_port
    if (we_i) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wbe_i[b]) begin
          mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read data only moves on a read strobe, so it holds while a response stalls.
  always_ff @(posedge clk_i or negedge clr_ni) begin : read_port
    if (!clr_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/memory_sram_be.sv
// Single-port SRAM with byte enables, backpressured read response and init sweep.
module memory_sram_be
  import memory_pkg::*;
#(
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     BE_WIDTH   = be_width(WIDTH),
  parameter int unsigned     ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  clr_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic                  init_req_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  accept;
  logic                  in_range;
  logic                  sweeping;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [WIDTH-1:0]      arr_wdata;
  logic [BE_WIDTH-1:0]   arr_wbe;

  assign sweeping = (state_q == INIT);
  assign busy_o   = sweeping;
  assign ready_o  = (state_q == IDLE) && !init_req_i && !(rvalid_o && !rready_i);
  assign accept   = valid_i && ready_o;
  assign in_range = {1'b0, addr_i} < DEPTH_EXT;

  // The sweep owns the write port; requests cannot be accepted meanwhile.
  assign arr_we    = sweeping || (accept && wr_rd_en_i && in_range);
  assign arr_waddr = sweeping ? cnt_q      : addr_i;
  assign arr_wdata = sweeping ? INIT_VALUE : wdata_i;
  assign arr_wbe   = sweeping ? '1         : be_i;

  always_ff @(posedge clk_i or negedge clr_ni) begin : fsm
    if (!clr_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (init_req_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A new read may be accepted in the same cycle the old response is consumed.
  always_ff @(posedge clk_i or negedge clr_ni) begin : response
    if (!clr_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (accept && !wr_rd_en_i) begin
        rvalid_o <= 1'b1;
      end else if (rready_i) begin
        rvalid_o <= 1'b0;
      end
      err_o <= accept && !in_range;
    end
  end

  mem_be_array #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .clr_ni  (clr_ni),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .wbe_i   (arr_wbe),
    .re_i    (accept && !wr_rd_en_i),
    .raddr_i (addr_i),
    .rzero_i (!in_range),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_memory_sram_be.sv
// Bench for memory_sram_be: a DEPTH=16 and a DEPTH=12 instance share one stimulus stream.
module tb_memory_sram_be;

  localparam logic [31:0] INIT12 = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        rready = 1'b1;
  logic        init_req = 1'b0;

  logic        ready16, rvalid16, busy16, err16;
  logic [31:0] rdata16;
  logic        ready12, rvalid12, busy12, err12;
  logic [31:0] rdata12;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic rnd_rr = 1'b0;

  always #5 clk = ~clk;

  memory_sram_be #(.DEPTH(16), .WIDTH(32), .INIT_VALUE(32'h0)) dut16 (
    .clk_i(clk), .clr_ni(rst_n), .valid_i(valid), .ready_o(ready16),
    .wr_rd_en_i(wr), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rdata_o(rdata16), .rvalid_o(rvalid16), .rready_i(rready),
    .init_req_i(init_req), .busy_o(busy16), .err_o(err16));

  memory_sram_be #(.DEPTH(12), .WIDTH(32), .INIT_VALUE(INIT12)) dut12 (
    .clk_i(clk), .clr_ni(rst_n), .valid_i(valid), .ready_o(ready12),
    .wr_rd_en_i(wr), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rdata_o(rdata12), .rvalid_o(rvalid12), .rready_i(rready),
    .init_req_i(init_req), .busy_o(busy12), .err_o(err12));

  // Reference model: index 0 is the DEPTH=16 instance, index 1 the DEPTH=12 one.
  int          m_busy [2];
  logic        m_rv   [2];
  logic [31:0] m_rd   [2];
  logic        m_err  [2];
  logic [31:0] m_mem  [2][16];
  logic        m_acc;

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] initv(input int k);
    return (k == 0) ? 32'h0 : INIT12;
  endfunction

  function automatic logic m_ready(input int k);
    return (m_busy[k] == 0) && !init_req && !(m_rv[k] && !rready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = dep(k);
        m_rv[k]   = 1'b0;
        m_rd[k]   = '0;
        m_err[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_acc    = valid && m_ready(k);
        m_err[k] = m_acc && (int'(addr) >= dep(k));
        if (m_acc && !wr) begin
          m_rv[k] = 1'b1;
          m_rd[k] = (int'(addr) >= dep(k)) ? 32'h0 : m_mem[k][addr];
        end else if (rready) begin
          m_rv[k] = 1'b0;
        end
        if (m_acc && wr && int'(addr) < dep(k)) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
        end
        if (m_busy[k] > 0) begin
          m_busy[k]--;
          if (m_busy[k] == 0)
            for (int i = 0; i < 16; i++) m_mem[k][i] = initv(k);
        end else if (init_req) begin
          m_busy[k] = dep(k);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready16",  ready16,  m_ready(0));
      check("cyc_rvalid16", rvalid16, m_rv[0]);
      check("cyc_rdata16",  rdata16,  m_rd[0]);
      check("cyc_busy16",   busy16,   m_busy[0] > 0);
      check("cyc_err16",    err16,    m_err[0]);
      check("cyc_ready12",  ready12,  m_ready(1));
      check("cyc_rvalid12", rvalid12, m_rv[1]);
      check("cyc_rdata12",  rdata12,  m_rd[1]);
      check("cyc_busy12",   busy12,   m_busy[1] > 0);
      check("cyc_err12",    err12,    m_err[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rr) rready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic req(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    logic acc;
    valid = 1'b1; wr = w; addr = a; wdata = d; be = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      acc = ready16;
      step();
      if (acc) begin
        valid = 1'b0;
        return;
      end
    end
    valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL req_timeout addr=%0d", a);
  endtask

  task automatic count_busy(input int exp16, input int exp12, input string tag);
    int c16, c12;
    c16 = 0;
    c12 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy16) c16++;
      if (busy12) c12++;
      if (!busy16 && !busy12) break;
    end
    check({tag, "_busy16_cycles"}, c16, exp16);
    check({tag, "_busy12_cycles"}, c12, exp12);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdata16"}, rdata16, 32'h0);
    check({tag, "_rvalid16"}, rvalid16, 1'b0);
    check({tag, "_err16"}, err16, 1'b0);
    check({tag, "_busy16"}, busy16, 1'b1);
    check({tag, "_ready16"}, ready16, 1'b0);
    check({tag, "_rdata12"}, rdata12, 32'h0);
    check({tag, "_rvalid12"}, rvalid12, 1'b0);
    check({tag, "_busy12"}, busy12, 1'b1);
    check({tag, "_ready12"}, ready12, 1'b0);
  endtask

  task automatic read_all(input string tag, input logic [31:0] v16, input logic [31:0] v12);
    for (int a = 0; a < 16; a++) begin
      req(1'b0, 4'(a), 32'h0, 4'h0);
      @(negedge clk);
      check({tag, "_rd16"}, rdata16, v16);
      check({tag, "_rd12"}, rdata12, (a < 12) ? v12 : 32'h0);
      check({tag, "_err12"}, err12, a >= 12);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp16;
    logic [31:0] exp12;
    logic        err12;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] b2b16 [3];
  logic [31:0] b2b12 [3];

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
    vecs[3]  = '{1'b1, 4'd5,  32'hCAFEF00D, 4'h0, 32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'h0,        INIT12,       1'b0};
    vecs[5]  = '{1'b1, 4'd13, 32'h12345678, 4'hF, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 4'd13, 32'h0,        4'h0, 32'h12345678, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 4'd11, 32'hFFFFFFFF, 4'h8, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{1'b0, 4'd11, 32'h0,        4'h0, 32'hFF000000, 32'hFF5A0F0F, 1'b0};
    vecs[9]  = '{1'b1, 4'd12, 32'h00000001, 4'h3, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 4'd12, 32'h0,        4'h0, 32'h00000001, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 4'd0,  32'hDEADBEEF, 4'h6, 32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b0, 4'd0,  32'h0,        4'h0, 32'h00ADBE00, 32'h5AADBE0F, 1'b0};
    b2b16 = '{32'h0, 32'h0, 32'hAA22CC44};
    b2b12 = '{INIT12, INIT12, 32'hAA22CC44};

    // Reset state and initial sweep length.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    chk_en = 1'b1;
    rst_n  = 1'b1;
    count_busy(16, 12, "por");
    read_all("post_init", 32'h0, INIT12);

    // Directed write/read vectors, including byte enables and out-of-range words.
    foreach (vecs[i]) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      @(negedge clk);
      check("vec_err12", err12, vecs[i].err12);
      check("vec_err16", err16, 1'b0);
      if (!vecs[i].wr) begin
        check("vec_rvalid16", rvalid16, 1'b1);
        check("vec_rdata16", rdata16, vecs[i].exp16);
        check("vec_rvalid12", rvalid12, 1'b1);
        check("vec_rdata12", rdata12, vecs[i].exp12);
      end
    end
    step();

    // Back-to-back reads at full throughput.
    valid = 1'b1;
    wr    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 4'(i + 1);
      @(negedge clk);
      check("b2b_ready", ready16, 1'b1);
      if (i > 0) begin
        check("b2b_rvalid", rvalid16, 1'b1);
        check("b2b_rdata16", rdata16, b2b16[i-1]);
        check("b2b_rdata12", rdata12, b2b12[i-1]);
      end
      step();
    end
    valid = 1'b0;
    @(negedge clk);
    check("b2b_rvalid_last", rvalid16, 1'b1);
    check("b2b_rdata16_last", rdata16, b2b16[2]);
    check("b2b_rdata12_last", rdata12, b2b12[2]);
    step();
    @(negedge clk);
    check("b2b_rvalid_drop", rvalid16, 1'b0);
    check("b2b_rdata_hold", rdata16, b2b16[2]);
    step();

    // Stalled response blocks the next request and holds its data.
    rready = 1'b0;
    req(1'b0, 4'd3, 32'h0, 4'h0);
    valid = 1'b1;
    addr  = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_ready", ready16, 1'b0);
      check("stall_rvalid", rvalid16, 1'b1);
      check("stall_rdata16", rdata16, 32'hAA22CC44);
      check("stall_rdata12", rdata12, 32'hAA22CC44);
      step();
    end
    rready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", ready16, 1'b1);
    step();
    valid = 1'b0;
    @(negedge clk);
    check("stall_next_rvalid", rvalid16, 1'b1);
    check("stall_next_rdata16", rdata16, 32'h0);
    check("stall_next_rdata12", rdata12, INIT12);
    step();

    // Init request wins over a simultaneous read.
    init_req = 1'b1;
    valid    = 1'b1;
    wr       = 1'b0;
    addr     = 4'd14;
    @(negedge clk);
    check("init_prio_ready16", ready16, 1'b0);
    check("init_prio_ready12", ready12, 1'b0);
    step();
    init_req = 1'b0;
    valid    = 1'b0;
    count_busy(16, 12, "init_req");
    read_all("post_req_init", 32'h0, INIT12);

    // Reset in the middle of a sweep restarts it from word 0.
    req(1'b1, 4'd4, 32'h13572468, 4'hF);
    req(1'b0, 4'd4, 32'h0, 4'h0);
    @(negedge clk);
    check("pre_rst_rdata16", rdata16, 32'h13572468);
    check("pre_rst_rdata12", rdata12, 32'h13572468);
    step();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_sweep_rst");
    repeat (2) step();
    rst_n = 1'b1;
    count_busy(16, 12, "rst_restart");
    read_all("post_rst", 32'h0, INIT12);

    // Randomised traffic with random response backpressure.
    rnd_rr = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 40 && (busy16 || busy12); i++) step();
      end else if ($urandom_range(0, 5) == 0) begin
        step();
      end else begin
        req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
    end
    rnd_rr = 1'b0;
    rready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
